// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and a constant clog2.
// Kept separate so the receiver can reuse the same encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side stream and line-status bundle for the UART transmitter.
interface uart_tx_frame_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  tx;
    logic                  tx_busy;
    logic                  tx_done;

    modport master (
        output s_valid, s_data,
        input  s_ready, tx, tx_busy, tx_done
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one s_tick every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
// clr restarts the period so the first tick lands a full period later.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic s_tick
);

    localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned CNT_W    = (clog2(TICK_DIV) > 0) ? clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // s_tick is a registered copy of "counter at its last value", aligned with cnt_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            s_tick <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            s_tick <= (cnt_d == CNT_LAST);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with one-word holding register, configurable stop bits and parity.
// Frames run back to back when a word is waiting at the end of the stop period.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BIT   = 1,
    parameter int unsigned PARITY     = 0
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_frame_if.slave  bus
);

    localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned BIT_W    = clog2(DATA_WIDTH);
    localparam int unsigned TICK_W   = clog2(OVERSAMPLE * 2);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_BIT * OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);

    if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9) || (STOP_BIT < 1) || (STOP_BIT > 2) ||
        (PARITY > PAR_EVEN) || (OVERSAMPLE < 1) || (TICK_DIV < 1)) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter combination");
    end

    uart_state_e             state_q;
    uart_state_e             state_d;
    logic [TICK_W-1:0]       tick_q;
    logic [TICK_W-1:0]       tick_d;
    logic [BIT_W-1:0]        bit_q;
    logic [BIT_W-1:0]        bit_d;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   shift_d;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic [DATA_WIDTH-1:0]   hold_d;
    logic                    hold_full_q;
    logic                    hold_full_d;
    logic                    par_q;
    logic                    par_d;
    logic                    tx_q;
    logic                    tx_d;
    logic                    busy_q;
    logic                    ready_q;
    logic                    load_shift;
    logic                    clr;
    logic                    done_c;
    logic                    s_tick;

    uart_baud_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .s_tick (s_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        load_shift  = 1'b0;
        clr         = 1'b0;
        done_c      = 1'b0;
        tx_d        = 1'b1;

        if (bus.s_valid && ready_q) begin
            hold_d      = bus.s_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load_shift = 1'b1;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        state_d = ST_DATA;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (tick_q == STOP_LAST) begin
                        tick_d = '0;
                        done_c = 1'b1;
                        if (hold_full_q) begin
                            load_shift = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Copy hold into the shifter; s_ready is low whenever hold is full, so no load collides.
        if (load_shift) begin
            state_d     = ST_START;
            shift_d     = hold_q;
            par_d       = (PARITY == PAR_EVEN) ? (^hold_q) : (~^hold_q);
            hold_full_d = 1'b0;
            clr         = 1'b1;
        end

        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            busy_q      <= (state_d != ST_IDLE);
            ready_q     <= !hold_full_d;
        end
    end

    // tx_done decodes registered state only: high for the last cycle of the final stop bit.
    assign bus.s_ready = ready_q;
    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_c;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: 8N1, 7E2 and 7O2 instances at 160 clocks per bit,
// fixed vector table, hand-written corner sequences and random frames against a line model.
module tb_uart_tx_frame;

    localparam int unsigned CLK_FREQ   = 1_600_000;
    localparam int unsigned BAUD_RATE  = 10_000;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int          BIT_CLK    = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2:0] valid_v = '0;
    logic [8:0] data_v  = '0;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] ready_v;

    uart_tx_frame_if #(.DATA_WIDTH(8)) if8  ();
    uart_tx_frame_if #(.DATA_WIDTH(7)) if7e ();
    uart_tx_frame_if #(.DATA_WIDTH(7)) if7o ();

    uart_tx_frame #(.DATA_WIDTH(8), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
                    .OVERSAMPLE(OVERSAMPLE), .STOP_BIT(1), .PARITY(0))
        u_8n1 (.clk(clk), .rst(rst), .bus(if8));
    uart_tx_frame #(.DATA_WIDTH(7), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
                    .OVERSAMPLE(OVERSAMPLE), .STOP_BIT(2), .PARITY(2))
        u_7e2 (.clk(clk), .rst(rst), .bus(if7e));
    uart_tx_frame #(.DATA_WIDTH(7), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
                    .OVERSAMPLE(OVERSAMPLE), .STOP_BIT(2), .PARITY(1))
        u_7o2 (.clk(clk), .rst(rst), .bus(if7o));

    assign if8.s_valid  = valid_v[0];
    assign if8.s_data   = data_v[7:0];
    assign if7e.s_valid = valid_v[1];
    assign if7e.s_data  = data_v[6:0];
    assign if7o.s_valid = valid_v[2];
    assign if7o.s_data  = data_v[6:0];
    assign tx_v    = {if7o.tx, if7e.tx, if8.tx};
    assign busy_v  = {if7o.tx_busy, if7e.tx_busy, if8.tx_busy};
    assign done_v  = {if7o.tx_done, if7e.tx_done, if8.tx_done};
    assign ready_v = {if7o.s_ready, if7e.s_ready, if8.s_ready};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fbits(input logic [1:0] sel);
        return (sel == 2'd0) ? 10 : 11;
    endfunction

    // Line levels per bit period, bit 0 first: start, data LSB first, optional parity, stops.
    function automatic logic [31:0] model_line(input logic [1:0] sel, input logic [8:0] d);
        logic [31:0] line;
        int          pos;
        int          dw;
        int          ones;
        line = '1;
        dw   = (sel == 2'd0) ? 8 : 7;
        ones = 0;
        line[0] = 1'b0;
        pos = 1;
        for (int i = 0; i < dw; i++) begin
            line[5'(pos)] = d[4'(i)];
            ones += int'(d[4'(i)]);
            pos++;
        end
        if (sel == 2'd1) line[5'(pos)] = (ones % 2 == 1);
        if (sel == 2'd2) line[5'(pos)] = (ones % 2 == 0);
        return line;
    endfunction

    task automatic send_word(input logic [1:0] sel, input logic [8:0] d, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        data_v  = d;
        valid_v = 3'(3'd1 << sel);
        while (ready_v[sel] !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        ok = (ready_v[sel] === 1'b1);
        @(posedge clk);
    endtask

    // Waits for the start-bit fall, then checks every cycle of nbits bit periods.
    task automatic check_line(input logic [1:0] sel, input logic [31:0] line, input int nbits,
                              input int fb, input int rlo, input int rhi, input string name);
        int n, c, bad_bit, bad_busy, bad_done, bad_ready, pulses;
        n = 0; bad_busy = 0; bad_done = 0; bad_ready = 0; pulses = 0;
        @(negedge clk);
        while (tx_v[sel] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, " fall_latency"}, n, 0);
        for (int k = 0; k < nbits; k++) begin
            bad_bit = 0;
            for (int j = 0; j < BIT_CLK; j++) begin
                c = k * BIT_CLK + j;
                if (tx_v[sel] !== line[5'(k)]) bad_bit++;
                if (busy_v[sel] !== 1'b1) bad_busy++;
                if (done_v[sel] === 1'b1) pulses++;
                if (done_v[sel] !== ((c % (fb * BIT_CLK)) == fb * BIT_CLK - 1)) bad_done++;
                if (ready_v[sel] !== !(c >= rlo && c <= rhi)) bad_ready++;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d_bad_cycles", name, k), bad_bit, 0);
        end
        check({name, " busy_bad_cycles"}, bad_busy, 0);
        check({name, " done_bad_cycles"}, bad_done, 0);
        check({name, " done_pulses"}, pulses, nbits / fb);
        check({name, " ready_bad_cycles"}, bad_ready, 0);
        check({name, " idle_tx"}, tx_v[sel], 1);
        check({name, " idle_busy"}, busy_v[sel], 0);
        check({name, " idle_done"}, done_v[sel], 0);
    endtask

    task automatic single_frame(input logic [1:0] sel, input logic [8:0] d,
                                input logic [31:0] line, input string name);
        bit ok;
        send_word(sel, d, ok);
        check({name, " accepted"}, 32'(ok), 1);
        @(negedge clk);
        valid_v = '0;
        data_v  = ~d;
        check({name, " lat_idle_tx"}, tx_v[sel], 1);
        check({name, " ready_full"}, ready_v[sel], 0);
        check_line(sel, line, fbits(sel), fbits(sel), 1, 0, name);
    endtask

    // Second word offered right after the first is accepted; optional data churn while hold is full.
    task automatic b2b(input logic [1:0] sel, input logic [8:0] d1, input logic [8:0] d2,
                       input logic [31:0] line, input bit scramble, input string name);
        bit ok, ok2;
        int n2, fb;
        ok2 = 1'b0;
        n2  = 0;
        fb  = fbits(sel);
        send_word(sel, d1, ok);
        check({name, " accepted1"}, 32'(ok), 1);
        fork
            begin
                @(negedge clk);
                data_v = d2;
                while (ready_v[sel] !== 1'b1 && n2 < 4000) begin
                    @(negedge clk);
                    n2++;
                end
                ok2 = (ready_v[sel] === 1'b1);
                @(posedge clk);
                if (scramble) begin
                    for (int i = 0; i < 1000; i++) begin
                        @(negedge clk);
                        data_v = 9'($urandom);
                    end
                end
                @(negedge clk);
                valid_v = '0;
            end
            begin
                @(negedge clk);
                check({name, " lat_idle_tx"}, tx_v[sel], 1);
                check_line(sel, line, 2 * fb, fb, 1, fb * BIT_CLK - 1, name);
            end
        join
        check({name, " accepted2"}, 32'(ok2), 1);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [8:0]  data;
        logic [31:0] line;
        string       name;
    } vec_t;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   bad;
        bit   ok;
        logic [1:0] sel;
        logic [8:0] d1, d2;

        vecs[0] = '{2'd0, 9'h0A5, {22'h3F_FFFF, 1'b1, 8'hA5, 1'b0}, "8n1_a5"};
        vecs[1] = '{2'd0, 9'h000, {22'h3F_FFFF, 1'b1, 8'h00, 1'b0}, "8n1_00"};
        vecs[2] = '{2'd0, 9'h0FF, {22'h3F_FFFF, 1'b1, 8'hFF, 1'b0}, "8n1_ff"};
        vecs[3] = '{2'd1, 9'h03B, {21'h1F_FFFF, 2'b11, 1'b1, 7'h3B, 1'b0}, "7e2_3b"};
        vecs[4] = '{2'd2, 9'h03B, {21'h1F_FFFF, 2'b11, 1'b0, 7'h3B, 1'b0}, "7o2_3b"};
        vecs[5] = '{2'd2, 9'h000, {21'h1F_FFFF, 2'b11, 1'b1, 7'h00, 1'b0}, "7o2_00"};

        // Reset state, then quiet idle with no valid.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset tx%0d", i), tx_v[i], 1);
            check($sformatf("reset ready%0d", i), ready_v[i], 1);
            check($sformatf("reset busy%0d", i), busy_v[i], 0);
            check($sformatf("reset done%0d", i), done_v[i], 0);
        end
        rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_v !== 3'b111 || busy_v !== 3'b000 || done_v !== 3'b000 || ready_v !== 3'b111) bad++;
        end
        check("idle_after_reset bad_cycles", bad, 0);

        for (int v = 0; v < 6; v++) begin
            single_frame(vecs[v].sel, vecs[v].data, vecs[v].line, vecs[v].name);
        end

        b2b(2'd0, 9'h055, 9'h00F,
            {12'hFFF, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0}, 1'b0, "b2b_55_0f");
        b2b(2'd0, 9'h012, 9'h034,
            {12'hFFF, 1'b1, 8'h34, 1'b0, 1'b1, 8'h12, 1'b0}, 1'b1, "backpressure");
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
        end
        check("backpressure no_extra_frame", bad, 0);

        // Reset during data bit 3 with a second word parked in hold.
        send_word(2'd0, 9'h0A5, ok);
        @(negedge clk);
        valid_v = '0;
        bad = 0;
        while (tx_v[0] !== 1'b0 && bad < 400) begin
            @(negedge clk);
            bad++;
        end
        for (int c = 0; c < 690; c++) begin
            if (c == 5) begin
                data_v  = 9'h077;
                valid_v = 3'b001;
            end
            if (c == 6) begin
                valid_v = '0;
                check("midrst hold_loaded_ready", ready_v[0], 0);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst tx", tx_v[0], 1);
        check("midrst busy", busy_v[0], 0);
        check("midrst done", done_v[0], 0);
        check("midrst ready", ready_v[0], 1);
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad++;
        end
        check("midrst stays_idle bad_cycles", bad, 0);
        single_frame(2'd0, 9'h03C, {22'h3F_FFFF, 1'b1, 8'h3C, 1'b0}, "after_rst_3c");

        // Random single frames on all configurations.
        for (int r = 0; r < 8; r++) begin
            sel = 2'($urandom_range(0, 2));
            d1  = 9'($urandom_range(0, (sel == 2'd0) ? 255 : 127));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            single_frame(sel, d1, model_line(sel, d1), $sformatf("rand%0d", r));
        end

        // Random back-to-back pairs on 8N1.
        for (int r = 0; r < 2; r++) begin
            d1 = 9'($urandom_range(0, 255));
            d2 = 9'($urandom_range(0, 255));
            b2b(2'd0, d1, d2, (model_line(2'd0, d2) << 10) | (model_line(2'd0, d1) & 32'h3FF),
                1'(r), $sformatf("rand_b2b%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
